// File: rtl/fir_coef_loader.sv
// Loads the tap coefficients for a distributed-arithmetic FIR, eight taps per group.
// For each group it builds the 256-entry partial-sum LUT and writes it word by word
// through the CIN/CADDR/CLOAD port.
//
// Ports:
//   clk, resetn           clock and asynchronous active-low reset
//   start                 one-cycle pulse that begins a session; only honoured in IDLE
//   coef_in, coef_valid   tap stream, one tap per transfer, taps in index order
//   coef_ready            high in COLLECT; a transfer is coef_valid && coef_ready
//   CIN, CADDR, CLOAD     registered LUT write port, CADDR = {group, pattern}
//   busy                  high whenever the loader is not idle
//   done                  one-cycle pulse after the last LUT word of the session
module fir_coef_loader #(
    parameter int unsigned NUM_GROUPS = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [15:0] coef_in,
    input  logic        coef_valid,
    output logic        coef_ready,
    output logic [19:0] CIN,
    output logic [10:0] CADDR,
    output logic        CLOAD,
    output logic        busy,
    output logic        done
);
    localparam int unsigned TAPS = 8;
    localparam int unsigned CW   = 16;
    localparam int unsigned OW   = 20;
    localparam int unsigned GW   = 3;
    localparam int unsigned PW   = 8;
    localparam int unsigned TW   = 3;
    localparam logic [GW-1:0] LAST_GRP = GW'(NUM_GROUPS - 1);
    localparam logic [PW-1:0] LAST_PAT = '1;
    localparam logic [TW-1:0] LAST_TAP = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [TW-1:0]         r_tap_cnt;
    logic [TW-1:0]         w_tap_cnt_nxt;
    logic [GW-1:0]         r_grp;
    logic [GW-1:0]         w_grp_nxt;
    logic [PW-1:0]         r_pat;
    logic [PW-1:0]         w_pat_nxt;
    logic                  w_cload_nxt;
    logic                  w_done_nxt;
    logic signed [CW-1:0]  r_taps [TAPS];
    logic signed [OW-1:0]  w_sum;

    logic                  r_cload;
    logic                  r_done;
    logic                  r_busy;
    logic                  r_ready;
    logic [OW-1:0]         r_cin;
    logic [GW+PW-1:0]      r_caddr;

    // State and counter register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_tap_cnt <= '0;
            r_grp     <= '0;
            r_pat     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tap_cnt <= w_tap_cnt_nxt;
            r_grp     <= w_grp_nxt;
            r_pat     <= w_pat_nxt;
        end
    end

    // Next-state and counter logic. Entering WRITE already presents pattern 0 so the
    // write port is busy on every WRITE cycle and drops right after pattern 255.
    always_comb begin
        w_state_nxt   = r_state;
        w_tap_cnt_nxt = r_tap_cnt;
        w_grp_nxt     = r_grp;
        w_pat_nxt     = r_pat;
        w_cload_nxt   = 1'b0;
        w_done_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt   = S_COLLECT;
                    w_tap_cnt_nxt = '0;
                    w_grp_nxt     = '0;
                end
            end
            S_COLLECT: begin
                if (coef_valid) begin
                    if (r_tap_cnt == LAST_TAP) begin
                        w_state_nxt   = S_WRITE;
                        w_tap_cnt_nxt = '0;
                        w_pat_nxt     = '0;
                        w_cload_nxt   = 1'b1;
                    end else begin
                        w_tap_cnt_nxt = r_tap_cnt + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (r_pat == LAST_PAT) begin
                    if (r_grp == LAST_GRP) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = S_COLLECT;
                        w_grp_nxt     = r_grp + 1'b1;
                        w_tap_cnt_nxt = '0;
                    end
                end else begin
                    w_pat_nxt   = r_pat + 1'b1;
                    w_cload_nxt = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Partial sum for the pattern about to be presented; 20 bits hold 8 x 16-bit exactly
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < int'(TAPS); i++) begin
            if (w_pat_nxt[i]) begin
                w_sum = w_sum + OW'(r_taps[i]);
            end
        end
    end

    // Tap capture, only on a COLLECT transfer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(TAPS); i++) begin
                r_taps[i] <= '0;
            end
        end else if (r_state == S_COLLECT && coef_valid) begin
            r_taps[r_tap_cnt] <= coef_in;
        end
    end

    // Registered outputs, derived from the next state so they line up with it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cload <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_cin   <= '0;
            r_caddr <= '0;
        end else begin
            r_cload <= w_cload_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_ready <= (w_state_nxt == S_COLLECT);
            if (w_cload_nxt) begin
                r_cin   <= w_sum;
                r_caddr <= {w_grp_nxt, w_pat_nxt};
            end
        end
    end

    assign CLOAD      = r_cload;
    assign done       = r_done;
    assign busy       = r_busy;
    assign coef_ready = r_ready;
    assign CIN        = r_cin;
    assign CADDR      = r_caddr;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Bench for fir_coef_loader: an 8-group instance driven by randomized sessions and a
// 1-group instance for the single-group timing scenario. The LUT reference is a plain
// integer sum over the taps selected by each pattern bit.
module tb_fir_coef_loader;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        start1 = 1'b0;
    logic [15:0] coef_in = '0;
    logic        coef_valid = 1'b0;

    logic        ready8, cload8, busy8, done8;
    logic [19:0] cin8;
    logic [10:0] caddr8;
    logic        ready1, cload1, busy1, done1;
    logic [19:0] cin1;
    logic [10:0] caddr1;

    fir_coef_loader #(.NUM_GROUPS(8)) dut8 (
        .clk(clk), .resetn(resetn), .start(start), .coef_in(coef_in),
        .coef_valid(coef_valid), .coef_ready(ready8), .CIN(cin8), .CADDR(caddr8),
        .CLOAD(cload8), .busy(busy8), .done(done8)
    );

    fir_coef_loader #(.NUM_GROUPS(1)) dut1 (
        .clk(clk), .resetn(resetn), .start(start1), .coef_in(coef_in),
        .coef_valid(coef_valid), .coef_ready(ready1), .CIN(cin1), .CADDR(caddr1),
        .CLOAD(cload1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic signed [15:0] taps [64];

    // Write/done recorders for both instances, sampled on the falling edge
    logic [10:0] wr_addr[$];
    logic [19:0] wr_data[$];
    int          wr_cyc[$];
    int          done_cyc[$];
    int          out_viol = 0;
    logic        done_prev = 1'b0;
    logic [10:0] w1_addr[$];
    logic [19:0] w1_data[$];
    int          w1_cyc[$];
    int          d1_cyc[$];

    always @(negedge clk) begin
        if (cload8) begin
            wr_addr.push_back(caddr8);
            wr_data.push_back(cin8);
            wr_cyc.push_back(cyc);
            if (ready8 || !busy8) out_viol++;
        end
        if (done8) begin
            done_cyc.push_back(cyc);
            if (done_prev || cload8 || !busy8) out_viol++;
        end
        done_prev = done8;
        if (cload1) begin
            w1_addr.push_back(caddr1);
            w1_data.push_back(cin1);
            w1_cyc.push_back(cyc);
        end
        if (done1) d1_cyc.push_back(cyc);
    end

    function automatic logic [19:0] model_word(input int g, input int p);
        int s;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            if (((p >> i) & 1) != 0) s += int'(taps[g*8+i]);
        end
        return 20'(s);
    endfunction

    // Scoreboard: number of recorded writes that differ from the full 2048-entry reference
    function automatic int lut_errors(output int first);
        int bad;
        bit ok;
        bad = 0;
        first = -1;
        if (wr_addr.size() != 2048) begin
            first = wr_addr.size();
            return 2048;
        end
        for (int k = 0; k < 2048; k++) begin
            ok = (wr_addr[k] == 11'(k)) && (wr_data[k] == model_word(k / 256, k % 256));
            if (k % 256 != 0 && wr_cyc[k] != wr_cyc[k-1] + 1) ok = 1'b0;
            if (!ok) begin
                if (first < 0) first = k;
                bad++;
            end
        end
        return bad;
    endfunction

    task automatic randomize_taps();
        for (int i = 0; i < 64; i++) taps[i] = 16'($urandom);
    endtask

    int stall_ready_bad;
    int stall_write_bad;

    // Drives one 8-group session; returns at the negedge where done is seen, or early
    // when the write at abort_addr is being presented.
    task automatic run_session(input int stall_grp, input int start_grp, input int abort_addr,
                               output bit aborted);
        int bound;
        aborted = 1'b0;
        stall_ready_bad = 0;
        stall_write_bad = 0;
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); done_cyc.delete();
        out_viol = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int g = 0; g < 8; g++) begin
            for (int t = 0; t < 8; t++) begin
                bound = 0;
                while (!ready8) begin
                    coef_in    = 16'($urandom);
                    coef_valid = 1'($urandom);
                    start = (start_grp >= 0 && cload8 && caddr8 == 11'(start_grp*256 + 50));
                    if (abort_addr >= 0 && cload8 && caddr8 == 11'(abort_addr)) begin
                        aborted = 1'b1;
                        coef_valid = 1'b0;
                        return;
                    end
                    @(negedge clk);
                    bound++;
                    if (bound > 2000) begin
                        checks++; fails++;
                        $display("FAIL session_timeout: coef_ready low for %0d cycles at group %0d tap %0d, required high", bound, g, t);
                        coef_valid = 1'b0;
                        start = 1'b0;
                        return;
                    end
                end
                start = 1'b0;
                coef_in    = taps[g*8+t];
                coef_valid = 1'b1;
                @(negedge clk);
                if (g == stall_grp && t == 2) begin
                    coef_valid = 1'b0;
                    repeat (5) begin
                        if (!ready8) stall_ready_bad++;
                        if (cload8) stall_write_bad++;
                        coef_in = 16'($urandom);
                        @(negedge clk);
                    end
                end
            end
        end
        coef_valid = 1'b0;
        bound = 0;
        while (!done8 && bound < 3000) begin
            @(negedge clk);
            bound++;
        end
        if (!done8) begin
            checks++; fails++;
            $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", done8, bound);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        coef_valid = 1'b1;
        repeat (3) begin
            coef_in = 16'($urandom);
            @(negedge clk);
        end
        checks += 6;
        if (cload8 !== 1'b0) begin fails++; $display("FAIL rst_cload: got %0b, required 0", cload8); end
        if (cin8 !== 20'd0) begin fails++; $display("FAIL rst_cin: got %h, required 0", cin8); end
        if (caddr8 !== 11'd0) begin fails++; $display("FAIL rst_caddr: got %h, required 0", caddr8); end
        if (busy8 !== 1'b0) begin fails++; $display("FAIL rst_busy: got %0b, required 0", busy8); end
        if (ready8 !== 1'b0) begin fails++; $display("FAIL rst_ready: got %0b, required 0", ready8); end
        if (done8 !== 1'b0) begin fails++; $display("FAIL rst_done: got %0b, required 0", done8); end
        resetn = 1'b1;
        wr_addr.delete();
        // Valid data in IDLE must be ignored and the block must stay idle
        repeat (6) begin
            coef_in = 16'($urandom);
            @(negedge clk);
        end
        coef_valid = 1'b0;
        checks += 3;
        if (busy8 !== 1'b0) begin fails++; $display("FAIL idle_busy: got %0b, required 0", busy8); end
        if (ready8 !== 1'b0) begin fails++; $display("FAIL idle_ready: got %0b, required 0", ready8); end
        if (wr_addr.size() != 0) begin fails++; $display("FAIL idle_writes: got %0d writes, required 0", wr_addr.size()); end
    endtask

    task automatic test_single_group();
        int s0, bound, bad;
        w1_addr.delete(); w1_data.delete(); w1_cyc.delete(); d1_cyc.delete();
        @(negedge clk);
        start1 = 1'b1;
        s0 = cyc;
        @(negedge clk);
        start1 = 1'b0;
        for (int t = 0; t < 8; t++) begin
            bound = 0;
            while (!ready1 && bound < 50) begin @(negedge clk); bound++; end
            coef_in = 16'(1 << t);
            coef_valid = 1'b1;
            @(negedge clk);
        end
        coef_valid = 1'b0;
        bound = 0;
        while (!done1 && bound < 400) begin @(negedge clk); bound++; end
        repeat (2) @(negedge clk);
        bad = 0;
        if (w1_addr.size() == 256) begin
            for (int p = 0; p < 256; p++) begin
                if (w1_addr[p] != 11'(p) || w1_data[p] != 20'(p) || w1_cyc[p] != w1_cyc[0] + p) bad++;
            end
        end else begin
            bad = 256;
        end
        checks += 4;
        if (bad != 0) begin fails++; $display("FAIL g1_lut: %0d bad of %0d writes, required 0 bad of 256", bad, w1_addr.size()); end
        if (d1_cyc.size() != 1) begin fails++; $display("FAIL g1_done_count: got %0d pulses, required 1", d1_cyc.size()); end
        else begin
            if (d1_cyc[0] - s0 != 265) begin fails++; $display("FAIL g1_latency: got %0d cycles start to done, required 265", d1_cyc[0] - s0); end
            if (w1_cyc.size() == 0 || d1_cyc[0] != w1_cyc[w1_cyc.size()-1] + 1) begin
                fails++; $display("FAIL g1_done_after_last: done at %0d, required one cycle after last write", d1_cyc[0]);
            end
        end
    endtask

    task automatic test_all_min();
        bit ab;
        int bad, first, minbad;
        for (int i = 0; i < 64; i++) taps[i] = 16'sh8000;
        run_session(-1, -1, -1, ab);
        repeat (3) @(negedge clk);
        bad = lut_errors(first);
        minbad = 0;
        for (int g = 0; g < 8; g++) begin
            if (wr_data.size() != 2048 || wr_data[g*256+255] != 20'hC0000) minbad++;
        end
        checks += 4;
        if (bad !== 0) begin fails++; $display("FAIL min_lut: %0d bad (first %0d), required 0", bad, first); end
        if (minbad !== 0) begin fails++; $display("FAIL min_p255: %0d groups wrong, required all CIN=c0000", minbad); end
        if (done_cyc.size() != 1) begin fails++; $display("FAIL min_done: got %0d pulses, required 1", done_cyc.size()); end
        if (out_viol !== 0) begin fails++; $display("FAIL min_outputs: %0d violations, required 0", out_viol); end
    endtask

    task automatic test_stall();
        bit ab;
        int bad, first;
        randomize_taps();
        run_session(2, -1, -1, ab);
        repeat (3) @(negedge clk);
        bad = lut_errors(first);
        checks += 3;
        if (stall_ready_bad !== 0) begin fails++; $display("FAIL stall_ready: low in %0d stall cycles, required 0", stall_ready_bad); end
        if (stall_write_bad !== 0) begin fails++; $display("FAIL stall_write: %0d writes during stall, required 0", stall_write_bad); end
        if (bad !== 0) begin fails++; $display("FAIL stall_lut: %0d bad (first %0d), required 0", bad, first); end
    endtask

    task automatic test_start_in_write();
        bit ab;
        int bad, first;
        randomize_taps();
        run_session(-1, 4, -1, ab);
        repeat (3) @(negedge clk);
        bad = lut_errors(first);
        checks += 3;
        if (bad !== 0) begin fails++; $display("FAIL restart_lut: %0d bad (first %0d), required 0", bad, first); end
        if (done_cyc.size() != 1) begin fails++; $display("FAIL restart_done: got %0d pulses, required 1", done_cyc.size()); end
        if (out_viol !== 0) begin fails++; $display("FAIL restart_outputs: %0d violations, required 0", out_viol); end
    endtask

    task automatic test_reset_mid_write();
        bit ab;
        int bad, first, nwr;
        randomize_taps();
        run_session(-1, -1, 3*256 + 100, ab);
        checks += 1;
        if (ab !== 1'b1) begin fails++; $display("FAIL abort_reached: got %0b, required write at group 3 p=100", ab); end
        resetn = 1'b0;
        #1;
        checks += 6;
        if (cload8 !== 1'b0) begin fails++; $display("FAIL midrst_cload: got %0b, required 0", cload8); end
        if (cin8 !== 20'd0) begin fails++; $display("FAIL midrst_cin: got %h, required 0", cin8); end
        if (caddr8 !== 11'd0) begin fails++; $display("FAIL midrst_caddr: got %h, required 0", caddr8); end
        if (busy8 !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %0b, required 0", busy8); end
        if (ready8 !== 1'b0) begin fails++; $display("FAIL midrst_ready: got %0b, required 0", ready8); end
        if (done8 !== 1'b0) begin fails++; $display("FAIL midrst_done: got %0b, required 0", done8); end
        nwr = wr_addr.size();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        checks += 2;
        if (wr_addr.size() != nwr) begin fails++; $display("FAIL midrst_writes: got %0d extra writes, required 0", wr_addr.size() - nwr); end
        if (busy8 !== 1'b0) begin fails++; $display("FAIL midrst_idle: busy=%0b after release, required 0", busy8); end
        randomize_taps();
        run_session(-1, -1, -1, ab);
        repeat (3) @(negedge clk);
        bad = lut_errors(first);
        checks += 1;
        if (bad !== 0) begin fails++; $display("FAIL reload_lut: %0d bad (first %0d), required 0", bad, first); end
    endtask

    task automatic test_random_sessions();
        bit ab;
        int bad, first;
        for (int s = 0; s < 20; s++) begin
            randomize_taps();
            run_session(-1, -1, -1, ab);
            repeat (2) @(negedge clk);
            bad = lut_errors(first);
            checks += 3;
            if (bad !== 0) begin fails++; $display("FAIL rand_lut[%0d]: %0d bad (first %0d), required 0", s, bad, first); end
            if (out_viol !== 0) begin fails++; $display("FAIL rand_outputs[%0d]: %0d violations, required 0", s, out_viol); end
            if (done_cyc.size() != 1 || wr_cyc.size() == 0 || done_cyc[0] != wr_cyc[wr_cyc.size()-1] + 1) begin
                fails++; $display("FAIL rand_done[%0d]: %0d pulses, required 1 right after last write", s, done_cyc.size());
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ab;
        int nwr;
        randomize_taps();
        run_session(-1, -1, -1, ab);
        // start raised in the DONE cycle must not begin a new session
        start = 1'b1;
        nwr = wr_addr.size();
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks += 3;
        if (busy8 !== 1'b0) begin fails++; $display("FAIL b2b_busy: got %0b, required 0", busy8); end
        if (ready8 !== 1'b0) begin fails++; $display("FAIL b2b_ready: got %0b, required 0", ready8); end
        if (wr_addr.size() != nwr) begin fails++; $display("FAIL b2b_writes: got %0d new writes, required 0", wr_addr.size() - nwr); end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, required $finish first");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_group();
        test_all_min();
        test_stall();
        test_start_in_write();
        test_reset_mid_write();
        test_random_sessions();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
